// File: rtl/z3_slave_cycle_engine.sv
// Zorro III slave cycle engine: claims a buffered-FCS cycle, routes it to one
// local target, waits for that target's ack and holds DTACK until FCS negates.
// A per-cycle data-phase timeout raises a bus-error request and bumps a
// saturating error counter.
module z3_slave_cycle_engine #(
   parameter int unsigned NUM_TARGETS    = 4,
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned ERRCNT_W       = 8,
   localparam int unsigned IDX_W = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1,
   localparam int unsigned TMR_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic                   CLK,
   input  logic                   RESET_n,
   input  logic                   bfcs,
   input  logic                   read,
   input  logic [3:0]             ds_n,
   input  logic                   match,
   input  logic                   validspace,
   input  logic [NUM_TARGETS-1:0] tgt_sel,
   input  logic [NUM_TARGETS-1:0] tgt_ack,
   output logic [NUM_TARGETS-1:0] tgt_req,
   output logic [IDX_W-1:0]       tgt_idx,
   output logic                   dtack,
   output logic                   berr,
   output logic                   busy,
   output logic [ERRCNT_W-1:0]    err_count
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_END   = 3'd3,
      ST_ERR   = 3'd4
   } state_t;

   state_t                 state;
   state_t                 state_d;
   logic [TMR_W-1:0]       timer;
   logic [TMR_W-1:0]       timer_d;
   logic [NUM_TARGETS-1:0] tgt_req_d;
   logic [IDX_W-1:0]       tgt_idx_d;
   logic                   dtack_d;
   logic                   berr_d;
   logic                   busy_d;
   logic [ERRCNT_W-1:0]    err_count_d;

   logic [IDX_W-1:0]       sel_idx;
   logic [NUM_TARGETS-1:0] claimed_onehot;
   logic                   claim;
   logic                   ack_hit;
   logic                   timeout_hit;

   // Lowest set bit of tgt_sel wins (index 0 has highest priority)
   always_comb begin
      sel_idx = '0;
      for (int i = int'(NUM_TARGETS) - 1; i >= 0; i--) begin
         if (tgt_sel[i]) begin
            sel_idx = IDX_W'(i);
         end
      end
   end

   // One-hot decode of the latched target index
   always_comb begin
      claimed_onehot = '0;
      for (int i = 0; i < int'(NUM_TARGETS); i++) begin
         claimed_onehot[i] = (tgt_idx == IDX_W'(i));
      end
   end

   // Cycle qualifiers; acks from targets other than the claimed one are masked
   always_comb begin
      claim       = bfcs && match && validspace && (|tgt_sel);
      ack_hit     = |(tgt_ack & claimed_onehot);
      timeout_hit = (TIMEOUT_CYCLES != 0) && (timer == TMR_W'(TIMEOUT_CYCLES - 1));
   end

   // Next-state and next-output logic
   always_comb begin
      state_d     = state;
      tgt_req_d   = '0;
      tgt_idx_d   = tgt_idx;
      dtack_d     = 1'b0;
      berr_d      = 1'b0;
      timer_d     = timer;
      err_count_d = err_count;
      busy_d      = 1'b0;

      case (state)
         ST_IDLE: begin
            if (claim) begin
               state_d   = ST_START;
               tgt_idx_d = sel_idx;
            end
         end

         ST_START: begin
            if (!bfcs) begin
               state_d = ST_IDLE;
            end else if (read || (ds_n != 4'b1111)) begin
               state_d   = ST_DATA;
               timer_d   = '0;
               tgt_req_d = claimed_onehot;
            end
         end

         ST_DATA: begin
            if (!bfcs) begin
               state_d = ST_IDLE;
            end else if (ack_hit) begin
               // ack has priority over a timeout on the same edge
               state_d = ST_END;
               dtack_d = 1'b1;
            end else if (timeout_hit) begin
               state_d = ST_ERR;
               berr_d  = 1'b1;
               if (err_count != {ERRCNT_W{1'b1}}) begin
                  err_count_d = err_count + ERRCNT_W'(1);
               end
            end else begin
               tgt_req_d = claimed_onehot;
               if (TIMEOUT_CYCLES != 0) begin
                  timer_d = timer + TMR_W'(1);
               end
            end
         end

         ST_END: begin
            if (!bfcs) begin
               state_d = ST_IDLE;
            end else begin
               dtack_d = 1'b1;
            end
         end

         ST_ERR: begin
            if (!bfcs) begin
               state_d = ST_IDLE;
            end else begin
               berr_d = 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Timer is only meaningful within a cycle; park it at zero in IDLE
      if (state_d == ST_IDLE) begin
         timer_d = '0;
      end
      busy_d = (state_d != ST_IDLE);
   end

   // State and registered outputs
   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         state     <= ST_IDLE;
         timer     <= '0;
         tgt_req   <= '0;
         tgt_idx   <= '0;
         dtack     <= 1'b0;
         berr      <= 1'b0;
         busy      <= 1'b0;
         err_count <= '0;
      end else begin
         state     <= state_d;
         timer     <= timer_d;
         tgt_req   <= tgt_req_d;
         tgt_idx   <= tgt_idx_d;
         dtack     <= dtack_d;
         berr      <= berr_d;
         busy      <= busy_d;
         err_count <= err_count_d;
      end
   end

endmodule

// File: tb/tb_z3_slave_cycle_engine.sv
// Scoreboard bench for z3_slave_cycle_engine: the driver queues the expected
// output tuple (and the edge it should appear on, counted from FCS assertion);
// the monitor pops and compares whenever the output tuple changes or a
// queued checkpoint falls due.
module tb_z3_slave_cycle_engine;

   localparam int unsigned NT = 4;

   logic          clk;
   logic          rst_n;
   logic          bfcs;
   logic          read;
   logic [3:0]    ds_n;
   logic          match;
   logic          validspace;
   logic [NT-1:0] tgt_sel;
   logic [NT-1:0] tgt_ack;
   logic [NT-1:0] tgt_req;
   logic [1:0]    tgt_idx;
   logic          dtack;
   logic          berr;
   logic          busy;
   logic [7:0]    err_count;

   z3_slave_cycle_engine #(
      .NUM_TARGETS   (4),
      .TIMEOUT_CYCLES(8),
      .ERRCNT_W      (8)
   ) dut (
      .CLK       (clk),
      .RESET_n   (rst_n),
      .bfcs      (bfcs),
      .read      (read),
      .ds_n      (ds_n),
      .match     (match),
      .validspace(validspace),
      .tgt_sel   (tgt_sel),
      .tgt_ack   (tgt_ack),
      .tgt_req   (tgt_req),
      .tgt_idx   (tgt_idx),
      .dtack     (dtack),
      .berr      (berr),
      .busy      (busy),
      .err_count (err_count)
   );

   typedef struct {
      string      name;
      logic       busy;
      logic [3:0] req;
      logic [1:0] idx;
      logic       dt;
      logic       be;
      logic [7:0] err;
      int         rel;   // edges after FCS assertion; -1 = don't care
      bit         sync;  // compare at rel even if nothing changed
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   int   mark   = 0;
   int   cur_err;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic raise(input logic rd, input logic [3:0] ds, input logic [3:0] sel);
      read       = rd;
      ds_n       = ds;
      tgt_sel    = sel;
      match      = 1'b1;
      validspace = 1'b1;
      bfcs       = 1'b1;
      mark       = cyc;
   endtask

   task automatic drop();
      bfcs       = 1'b0;
      match      = 1'b0;
      validspace = 1'b0;
      tgt_sel    = '0;
      tgt_ack    = '0;
      read       = 1'b0;
      ds_n       = 4'b1111;
   endtask

   task automatic ex(input string nm, input logic e_busy, input logic [3:0] e_req,
                     input logic [1:0] e_idx, input logic e_dt, input logic e_be,
                     input logic [7:0] e_err, input int e_rel, input bit e_sync);
      exp_t e;
      e.name = nm;   e.busy = e_busy; e.req = e_req; e.idx = e_idx;
      e.dt   = e_dt; e.be   = e_be;   e.err = e_err; e.rel = e_rel; e.sync = e_sync;
      q.push_back(e);
   endtask

   // Monitor: pop on any output change or due checkpoint, compare against head
   initial begin : monitor
      logic [16:0] prev_t;
      logic [16:0] cur_t;
      bit          first;
      bit          take;
      int          rel;
      exp_t        e;
      first  = 1'b1;
      prev_t = '0;
      forever begin
         @(negedge clk);
         cur_t = {busy, tgt_req, tgt_idx, dtack, berr, err_count};
         rel   = cyc - mark;
         take  = 1'b0;
         if (q.size() > 0 && q[0].sync && (q[0].rel < 0 || q[0].rel == rel)) take = 1'b1;
         else if (!first && cur_t != prev_t) take = 1'b1;
         if (take) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_change rel=%0d: got busy=%b req=%b idx=%0d dtack=%b berr=%b err=%0d, required no change",
                        rel, busy, tgt_req, tgt_idx, dtack, berr, err_count);
            end else begin
               e = q.pop_front();
               if (busy !== e.busy || tgt_req !== e.req || tgt_idx !== e.idx ||
                   dtack !== e.dt || berr !== e.be || err_count !== e.err ||
                   (e.rel >= 0 && rel != e.rel)) begin
                  errors++;
                  $display("FAIL %s: got rel=%0d busy=%b req=%b idx=%0d dtack=%b berr=%b err=%0d, required rel=%0d busy=%b req=%b idx=%0d dtack=%b berr=%b err=%0d",
                           e.name, rel, busy, tgt_req, tgt_idx, dtack, berr, err_count,
                           e.rel, e.busy, e.req, e.idx, e.dt, e.be, e.err);
               end
            end
         end
         prev_t = cur_t;
         first  = 1'b0;
      end
   end

   // Driver
   initial begin
      rst_n = 1'b0;
      drop();
      ex("reset_state", 0, 4'b0000, 0, 0, 0, 0, -1, 1);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick(2);

      // Read to target 2, ack after two wait clocks in DATA
      raise(1, 4'hF, 4'b0100);
      ex("t1_claim", 1, 4'b0000, 2, 0, 0, 0, 1, 0);
      ex("t1_data",  1, 4'b0100, 2, 0, 0, 0, 2, 0);
      ex("t1_dtack", 1, 4'b0000, 2, 1, 0, 0, 5, 0);
      ex("t1_idle",  0, 4'b0000, 2, 0, 0, 0, 8, 0);
      tick(4); tgt_ack = 4'b0100;
      tick(1); tgt_ack = 4'b0000;
      tick(2); drop();
      tick(3);

      // Multi-hot select: target 1 claimed, ack[1] held high
      tgt_ack = 4'b0010;
      raise(1, 4'hF, 4'b0110);
      ex("t2_claim", 1, 4'b0000, 1, 0, 0, 0, 1, 0);
      ex("t2_data",  1, 4'b0010, 1, 0, 0, 0, 2, 0);
      ex("t2_dtack", 1, 4'b0000, 1, 1, 0, 0, 3, 0);
      ex("t2_idle",  0, 4'b0000, 1, 0, 0, 0, 5, 0);
      tick(3); tgt_ack = 4'b0110;
      tick(1); drop();
      tick(3);

      // Multi-hot select: ack[2] early must be ignored, ack[1] late ends cycle
      tgt_ack = 4'b0100;
      raise(1, 4'hF, 4'b0110);
      ex("t2b_claim", 1, 4'b0000, 1, 0, 0, 0, 1, 0);
      ex("t2b_data",  1, 4'b0010, 1, 0, 0, 0, 2, 0);
      ex("t2b_dtack", 1, 4'b0000, 1, 1, 0, 0, 5, 0);
      ex("t2b_idle",  0, 4'b0000, 1, 0, 0, 0, 6, 0);
      tick(4); tgt_ack = 4'b0110;
      tick(1); drop();
      tick(3);

      // Write with strobes inactive for 5 clocks stays in START
      raise(0, 4'hF, 4'b0001);
      ex("t3_claim",      1, 4'b0000, 0, 0, 0, 0, 1, 0);
      ex("t3_hold_start", 1, 4'b0000, 0, 0, 0, 0, 6, 1);
      tick(6); ds_n = 4'b0000; tgt_ack = 4'b0001;
      ex("t3_data",  1, 4'b0001, 0, 0, 0, 0, 7, 0);
      ex("t3_dtack", 1, 4'b0000, 0, 1, 0, 0, 8, 0);
      ex("t3_idle",  0, 4'b0000, 0, 0, 0, 0, 9, 0);
      tick(2); drop();
      tick(3);

      // Timeout: no ack, berr after 8th DATA clock
      raise(1, 4'hF, 4'b1000);
      ex("t4_claim",     1, 4'b0000, 3, 0, 0, 0, 1,  0);
      ex("t4_data",      1, 4'b1000, 3, 0, 0, 0, 2,  0);
      ex("t4_berr",      1, 4'b0000, 3, 0, 1, 1, 10, 0);
      ex("t4_berr_held", 1, 4'b0000, 3, 0, 1, 1, 11, 1);
      ex("t4_idle",      0, 4'b0000, 3, 0, 0, 1, 12, 0);
      tick(11); drop();
      tick(3);

      // Ack on the exact timeout edge wins
      raise(1, 4'hF, 4'b0001);
      ex("t5_claim", 1, 4'b0000, 0, 0, 0, 1, 1,  0);
      ex("t5_data",  1, 4'b0001, 0, 0, 0, 1, 2,  0);
      ex("t5_dtack", 1, 4'b0000, 0, 1, 0, 1, 10, 0);
      ex("t5_idle",  0, 4'b0000, 0, 0, 0, 1, 11, 0);
      tick(9); tgt_ack = 4'b0001;
      tick(1); drop();
      tick(3);

      // Non-claims: empty select, no match, invalid space
      raise(1, 4'hF, 4'b0000);
      ex("t6_no_sel", 0, 4'b0000, 0, 0, 0, 1, 3, 1);
      tick(3); drop(); tick(2);
      raise(1, 4'hF, 4'b0010); match = 1'b0;
      ex("t6_no_match", 0, 4'b0000, 0, 0, 0, 1, 3, 1);
      tick(3); drop(); tick(2);
      raise(1, 4'hF, 4'b0010); validspace = 1'b0;
      ex("t6_no_space", 0, 4'b0000, 0, 0, 0, 1, 3, 1);
      tick(3); drop(); tick(2);

      // FCS dropped in START
      raise(1, 4'hF, 4'b0100);
      ex("t6b_claim", 1, 4'b0000, 2, 0, 0, 1, 1, 0);
      ex("t6b_idle",  0, 4'b0000, 2, 0, 0, 1, 2, 0);
      tick(1); drop();
      tick(3);

      // 255 more timeouts: counter saturates at 255
      cur_err = 1;
      for (int n = 0; n < 255; n++) begin
         raise(1, 4'hF, 4'b1000);
         ex("t8_claim", 1, 4'b0000, 3, 0, 0, 8'(cur_err), 1, 0);
         ex("t8_data",  1, 4'b1000, 3, 0, 0, 8'(cur_err), 2, 0);
         cur_err = (cur_err >= 255) ? 255 : cur_err + 1;
         ex("t8_berr",  1, 4'b0000, 3, 0, 1, 8'(cur_err), 10, 0);
         ex("t8_idle",  0, 4'b0000, 3, 0, 0, 8'(cur_err), 11, 0);
         tick(10); drop();
         tick(2);
      end
      tick(2);

      // FCS dropped in DATA
      raise(1, 4'hF, 4'b0100);
      ex("t7_claim", 1, 4'b0000, 2, 0, 0, 8'd255, 1, 0);
      ex("t7_data",  1, 4'b0100, 2, 0, 0, 8'd255, 2, 0);
      ex("t7_idle",  0, 4'b0000, 2, 0, 0, 8'd255, 3, 0);
      tick(2); drop();
      tick(3);

      // Async reset pulse during END clears everything including err_count
      tgt_ack = 4'b0010;
      raise(1, 4'hF, 4'b0010);
      ex("t7r_claim", 1, 4'b0000, 1, 0, 0, 8'd255, 1, 0);
      ex("t7r_data",  1, 4'b0010, 1, 0, 0, 8'd255, 2, 0);
      ex("t7r_dtack", 1, 4'b0000, 1, 1, 0, 8'd255, 3, 0);
      ex("t7r_reset", 0, 4'b0000, 0, 0, 0, 8'd0,   4, 0);
      ex("t7r_quiet", 0, 4'b0000, 0, 0, 0, 8'd0,   7, 1);
      tick(4);
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      drop();
      tick(5);

      for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expectations, required 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
